// File: rtl/w5300_socket_n_rx_pkg.sv
// w5300_socket_n_rx_pkg: W5300 bus direction, socket register offsets, RECV command, RX FSM states.
// CR_POLL is only a state when W5300_RX_CR_POLL_EN is defined.
package w5300_socket_n_rx_pkg;
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;
  localparam logic [9:0] SN_CR = 10'h002;
  localparam logic [9:0] SN_RX_RSR = 10'h028;
  localparam logic [9:0] SN_RX_RSR2 = 10'h02A;
  localparam logic [9:0] SN_RX_FIFOR = 10'h030;
  localparam logic [15:0] SOCK_RECV = 16'h0040;
  typedef enum logic [2:0] {
    IDLE,
    RSR_HIGH,
    RSR_LOW,
    PKT_SIZE,
    DATA,
    RECV,
`ifdef W5300_RX_CR_POLL_EN
    CR_POLL,
`endif
    FINISH
  } state_t;
endpackage

// File: rtl/w5300_socket_n_rx.sv
// w5300_socket_n_rx: drains one frame from a W5300 socket RX FIFO into a halfword buffer.
// Define W5300_RX_CR_POLL_EN to poll Sn_CR after RECV until the command clears.
module w5300_socket_n_rx
  import w5300_socket_n_rx_pkg::*;
#(
  parameter int N = 0,
  parameter int ETH_RX_BUFFER_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  output logic                           done,
  output logic [10:0]                    addr,
  output logic [15:0]                    wr_data,
  input  logic [15:0]                    rd_data,
  input  logic                           op_state,
  output logic                           eth_rx_req,
  output logic [ETH_RX_BUFFER_WIDTH-1:0] eth_rx_buffer_addr,
  output logic [15:0]                    eth_rx_buffer_data,
  output logic                           eth_rx_buffer_wr,
  output logic [15:0]                    eth_rx_len
);
  localparam logic [9:0] BASE = 10'(10'h200 + 10'h40 * N);
  localparam logic [16:0] DEPTH = 17'(2 ** ETH_RX_BUFFER_WIDTH);
  state_t state, state_nx;
  logic [10:0] addr_nx;
  logic [15:0] wr_data_nx, rsr_high, hw_cnt, hw_total;
  logic got_len, last_hw, rsr_nz;
  assign last_hw = 16'(hw_cnt + 16'd1) == hw_total;
  assign rsr_nz = |{rsr_high, rd_data};
  assign done = state == FINISH;
  assign eth_rx_req = done & got_len;
  always_comb begin
    state_nx = state;
    addr_nx = addr;
    wr_data_nx = wr_data;
    case (state)
      IDLE: if (enable) begin
        state_nx = RSR_HIGH;
        addr_nx = {RD, BASE + SN_RX_RSR};
      end
      RSR_HIGH: if (op_state) begin
        state_nx = RSR_LOW;
        addr_nx = {RD, BASE + SN_RX_RSR2};
      end
      RSR_LOW: if (op_state) begin
        state_nx = rsr_nz ? PKT_SIZE : FINISH;
        addr_nx = rsr_nz ? {RD, BASE + SN_RX_FIFOR} : {RD, 10'h000};
      end
      // a zero-length packet skips straight to the RECV command
      PKT_SIZE: if (op_state) begin
        state_nx = |rd_data ? DATA : RECV;
        addr_nx = |rd_data ? addr : {WR, BASE + SN_CR};
        wr_data_nx = |rd_data ? wr_data : SOCK_RECV;
      end
      DATA: if (op_state && last_hw) begin
        state_nx = RECV;
        addr_nx = {WR, BASE + SN_CR};
        wr_data_nx = SOCK_RECV;
      end
      RECV: if (op_state) begin
`ifdef W5300_RX_CR_POLL_EN
        state_nx = CR_POLL;
        addr_nx = {RD, BASE + SN_CR};
`else
        state_nx = FINISH;
        addr_nx = {RD, 10'h000};
`endif
        wr_data_nx = '0;
      end
`ifdef W5300_RX_CR_POLL_EN
      CR_POLL: if (op_state && rd_data == '0) begin
        state_nx = FINISH;
        addr_nx = {RD, 10'h000};
      end
`endif
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr <= {RD, 10'h000};
      wr_data <= '0;
      rsr_high <= '0;
      hw_cnt <= '0;
      hw_total <= '0;
      got_len <= 1'b0;
      eth_rx_len <= '0;
      eth_rx_buffer_addr <= '0;
      eth_rx_buffer_data <= '0;
      eth_rx_buffer_wr <= 1'b0;
    end else begin
      state <= state_nx;
      addr <= addr_nx;
      wr_data <= wr_data_nx;
      eth_rx_buffer_wr <= 1'b0;
      if (state == IDLE) got_len <= 1'b0;
      if (op_state)
        case (state)
          RSR_HIGH: rsr_high <= rd_data;
          PKT_SIZE: begin
            eth_rx_len <= rd_data;
            hw_total <= (rd_data >> 1) + {15'd0, rd_data[0]};
            hw_cnt <= '0;
            got_len <= |rd_data;
          end
          // halfwords past the buffer end are drained from the FIFO but dropped
          DATA: begin
            hw_cnt <= hw_cnt + 16'd1;
            if ({1'b0, hw_cnt} < DEPTH) begin
              eth_rx_buffer_wr <= 1'b1;
              eth_rx_buffer_addr <= ETH_RX_BUFFER_WIDTH'(hw_cnt);
              eth_rx_buffer_data <= rd_data;
            end
          end
          default: ;
        endcase
    end
endmodule
